hilo_div_ctrl: RTL and testbench

- Iterative restoring divider and sequencer for the HI/LO register pair.
- Accepts a divide request from EX and holds the pipeline stalled while it iterates, one quotient bit per cycle.
- Presents the remainder on the HI data path and the quotient on the LO data path, with a HI/LO write enable.
- Sits between EX and the HI/LO register; EX muxes its outputs into the HI/LO write path.

---
 rtl/hilo_div_if.sv | 29 ++
 rtl/hilo_div_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_hilo_div_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/hilo_div_if.sv
// hilo_div_if: EX <-> divider handshake and result bundle.
//   master (EX side)      : drives start_i, signed_i, annul_i, opdata1_i, opdata2_i;
//                           receives stall_o, ready_o, hilo_we_o, hi_o, lo_o.
//   slave  (divider side) : the mirror image.
// WIDTH is the operand width; it must match the divider's WIDTH.
interface hilo_div_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic             annul_i;
  logic [WIDTH-1:0] opdata1_i;
  logic [WIDTH-1:0] opdata2_i;
  logic             stall_o;
  logic             ready_o;
  logic             hilo_we_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    input  stall_o, ready_o, hilo_we_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    output stall_o, ready_o, hilo_we_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: iterative restoring divider sequencing the HI/LO register pair.
// One quotient bit is produced per cycle while the EX pipeline is stalled.
// The remainder is presented on hi_o and the quotient on lo_o, with a single
// hilo_we_o pulse on the first cycle the result is valid.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - hilo_div_if.slave: start_i/signed_i/annul_i/opdata1_i/opdata2_i in,
//          stall_o/ready_o/hilo_we_o/hi_o/lo_o out
//
// Build option: define HILO_DIV_SIGNED_EN to honour signed_i (DIV). Without it
// every divide is unsigned (DIVU) and signed_i is ignored.
module hilo_div_ctrl #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  hilo_div_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_DIVZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_END     = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ready_r;
  logic             we_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  // Datapath: dvd shifts dividend bits out of its MSB while quotient bits
  // shift into its LSB, so after WIDTH steps it holds the raw quotient.
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] orig_dvd;

  logic             accept;
  logic             busy;
  logic             last_step;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

`ifdef HILO_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? neg_val(x) : x;
  endfunction
`else
  logic unused_signed;
  assign unused_signed = bus.signed_i;
`endif

  // rst is folded in so stall_o reads 0 the instant reset is applied, even
  // while EX still holds start_i.
  assign accept    = rst & (state == ST_FREE) & bus.start_i & ~bus.annul_i;
  assign busy      = (state == ST_ON) || (state == ST_DIVZERO);
  assign bus.stall_o = accept | (rst & busy & ~bus.annul_i);

  // One restoring step: shifted remainder minus divisor, borrow decides the bit.
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
  assign diff      = {rem, dvd[WIDTH-1]} - {1'b0, dvs};
  assign q_bit     = ~diff[WIDTH];
  assign rem_nxt   = q_bit ? diff[WIDTH-1:0] : {rem[WIDTH-2:0], dvd[WIDTH-1]};
  assign quo_nxt   = {dvd[WIDTH-2:0], q_bit};

`ifdef HILO_DIV_SIGNED_EN
  // Quotient negative when signs differ; remainder follows the dividend.
  assign q_fin = neg_q ? neg_val(quo_nxt) : quo_nxt;
  assign r_fin = neg_r ? neg_val(rem_nxt) : rem_nxt;
`else
  assign q_fin = quo_nxt;
  assign r_fin = rem_nxt;
`endif

  assign bus.ready_o   = ready_r;
  assign bus.hilo_we_o = we_r;
  assign bus.hi_o      = hi_r;
  assign bus.lo_o      = lo_r;

  // Control sequencer and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_FREE;
      cnt     <= '0;
      ready_r <= 1'b0;
      we_r    <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      we_r <= 1'b0;
      case (state)
        ST_FREE: begin
          if (accept) begin
            cnt   <= '0;
            state <= (bus.opdata2_i == '0) ? ST_DIVZERO : ST_ON;
          end
        end
        ST_ON: begin
          if (bus.annul_i) begin
            state <= ST_FREE;
          end else begin
            cnt <= cnt + 1'b1;
            if (last_step) begin
              state   <= ST_END;
              ready_r <= 1'b1;
              we_r    <= 1'b1;
              hi_r    <= r_fin;
              lo_r    <= q_fin;
            end
          end
        end
        ST_DIVZERO: begin
          if (bus.annul_i) begin
            state <= ST_FREE;
          end else begin
            state   <= ST_END;
            ready_r <= 1'b1;
            we_r    <= 1'b1;
            hi_r    <= orig_dvd;
            lo_r    <= '1;
          end
        end
        ST_END: begin
          // Result holds while EX keeps start_i high; new requests wait for FREE.
          if (bus.annul_i || !bus.start_i) begin
            state   <= ST_FREE;
            ready_r <= 1'b0;
          end
        end
        default: state <= ST_FREE;
      endcase
    end
  end

  // Operand capture and iteration.
  always_ff @(posedge clk) begin
    if (accept) begin
      orig_dvd <= bus.opdata1_i;
      rem      <= '0;
`ifdef HILO_DIV_SIGNED_EN
      if (bus.signed_i) begin
        dvd   <= abs_val($signed(bus.opdata1_i));
        dvs   <= abs_val($signed(bus.opdata2_i));
        neg_q <= bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1];
        neg_r <= bus.opdata1_i[WIDTH-1];
      end else begin
        dvd   <= bus.opdata1_i;
        dvs   <= bus.opdata2_i;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end
`else
      dvd <= bus.opdata1_i;
      dvs <= bus.opdata2_i;
`endif
    end else if (state == ST_ON) begin
      rem <= rem_nxt;
      dvd <= quo_nxt;
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl: scoreboard bench for hilo_div_ctrl. Expected results are
// queued when a request is driven and popped when ready_o appears.
module tb_hilo_div_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_div_if #(.WIDTH(W)) bus ();

  hilo_div_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic drive_idle();
    bus.start_i   = 1'b0;
    bus.signed_i  = 1'b0;
    bus.annul_i   = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input int elat, input int hold, input string name);
    exp_t e;
    exp_t g;
    int   lat;
    int   stall_err;
    int   hold_err;
    int   we_cnt;
    e.hi = ehi; e.lo = elo; e.lat = elat;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.signed_i = sgn; bus.opdata1_i = a; bus.opdata2_i = b;
    @(negedge clk);
    total++;
    if (bus.stall_o !== 1'b1) begin
      bad++; $display("FAIL %s stall_cycle0 got=%b want=1", name, bus.stall_o);
    end
    lat = 0; stall_err = 0;
    while (bus.ready_o !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      // operands are only sampled at acceptance; scramble them afterwards
      bus.opdata1_i = $urandom; bus.opdata2_i = $urandom; bus.signed_i = ~sgn;
      @(negedge clk);
      lat++;
      if (bus.ready_o !== 1'b1 && bus.stall_o !== 1'b1) stall_err++;
    end
    g = sb_q.pop_front();
    total++;
    if (lat != g.lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, g.lat); end
    total++;
    if (bus.hi_o !== g.hi) begin bad++; $display("FAIL %s hi got=%h want=%h", name, bus.hi_o, g.hi); end
    total++;
    if (bus.lo_o !== g.lo) begin bad++; $display("FAIL %s lo got=%h want=%h", name, bus.lo_o, g.lo); end
    total++;
    if (bus.hilo_we_o !== 1'b1) begin bad++; $display("FAIL %s we_at_ready got=%b want=1", name, bus.hilo_we_o); end
    total++;
    if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL %s stall_at_ready got=%b want=0", name, bus.stall_o); end
    total++;
    if (stall_err != 0) begin bad++; $display("FAIL %s stall_while_busy lowcycles=%0d want=0", name, stall_err); end
    we_cnt = (bus.hilo_we_o === 1'b1) ? 1 : 0;
    hold_err = 0;
    repeat (hold) begin
      @(posedge clk); @(negedge clk);
      if (bus.hilo_we_o === 1'b1) we_cnt++;
      if (bus.ready_o !== 1'b1 || bus.hi_o !== g.hi || bus.lo_o !== g.lo) hold_err++;
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(negedge clk);
    if (bus.hilo_we_o === 1'b1) we_cnt++;
    if (bus.ready_o !== 1'b1) hold_err++;
    @(posedge clk); @(negedge clk);
    if (bus.hilo_we_o === 1'b1) we_cnt++;
    total++;
    if (hold_err != 0) begin bad++; $display("FAIL %s result_hold errs=%0d want=0", name, hold_err); end
    total++;
    if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL %s ready_after_exit got=%b want=0", name, bus.ready_o); end
    total++;
    if (we_cnt != 1) begin bad++; $display("FAIL %s we_pulses got=%0d want=1", name, we_cnt); end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL reset stall got=%b want=0", bus.stall_o); end
    total++;
    if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL reset ready got=%b want=0", bus.ready_o); end
    total++;
    if (bus.hilo_we_o !== 1'b0) begin bad++; $display("FAIL reset we got=%b want=0", bus.hilo_we_o); end
    total++;
    if (bus.hi_o !== '0 || bus.lo_o !== '0) begin
      bad++; $display("FAIL reset hilo got=%h/%h want=0/0", bus.hi_o, bus.lo_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL reset idle_stall got=%b want=0", bus.stall_o); end
  endtask

  task automatic test_unsigned();
    run_op(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 33, 0, "udiv_100_7");
    run_op(32'hFFFF_FFFF, 32'd16, 1'b0, 32'hF, 32'h0FFF_FFFF, 33, 0, "udiv_max_16");
  endtask

  task automatic test_signed();
`ifdef HILO_DIV_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0, "sdiv_m7_2");
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD, 33, 0, "sdiv_7_m2");
`else
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h0000_0001, 32'h7FFF_FFFC, 33, 0, "sdiv_off");
`endif
  endtask

  task automatic test_divzero();
    run_op(32'd5, 32'd0, 1'b0, 32'd5, 32'hFFFF_FFFF, 2, 0, "divzero");
  endtask

  task automatic test_annul();
    int errs;
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
    repeat (10) @(posedge clk);
    #1 bus.annul_i = 1'b1;
    @(negedge clk);
    total++;
    if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL annul stall_same_cycle got=%b want=0", bus.stall_o); end
    @(posedge clk); #1;
    bus.annul_i = 1'b0; bus.start_i = 1'b0;
    errs = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o !== 1'b0 || bus.hilo_we_o !== 1'b0 || bus.stall_o !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL annul quiet_after errs=%0d want=0", errs); end
    run_op(32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 33, 0, "after_annul_9_3");
  endtask

  task automatic test_overflow();
`ifdef HILO_DIV_SIGNED_EN
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, 33, 3, "overflow");
`else
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 33, 3, "overflow_u");
`endif
  endtask

  task automatic test_rst_mid();
    int errs;
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3;
    repeat (15) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total++;
    if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL rst_mid stall got=%b want=0", bus.stall_o); end
    total++;
    if (bus.ready_o !== 1'b0 || bus.hilo_we_o !== 1'b0) begin
      bad++; $display("FAIL rst_mid ready_we got=%b/%b want=0/0", bus.ready_o, bus.hilo_we_o);
    end
    total++;
    if (bus.hi_o !== '0 || bus.lo_o !== '0) begin
      bad++; $display("FAIL rst_mid hilo got=%h/%h want=0/0", bus.hi_o, bus.lo_o);
    end
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    errs = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.stall_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.hilo_we_o !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL rst_mid idle_after errs=%0d want=0", errs); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_annul();
    test_overflow();
    test_rst_mid();
    total++;
    if (sb_q.size() != 0) begin bad++; $display("FAIL scoreboard leftover got=%0d want=0", sb_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
